// File: rtl/serdes_pkg.sv
// serdes_pkg: shared types and helpers for the serializer transmit scheduler.
package serdes_pkg;

    typedef enum logic [1:0] {IDLE, HDR, PAY, DRAIN} state_t;

    localparam logic [5:0] HDR_MARK_DEF = 6'b101101;

    function automatic int clog2(input int n);
        int r;
        for (r = 0; (1 << r) < n; r++) begin
        end
        return r;
    endfunction

    function automatic logic [3:0] onehot_to_bin(input logic [15:0] oh);
        logic [3:0] b;
        b = '0;
        for (int i = 0; i < 16; i++)
            if (oh[i]) b = b | 4'(i);
        return b;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// rr_arbiter: combinational round-robin pick of the first request at or after ptr.
module rr_arbiter
    import serdes_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int ID_W    = clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req_i,
    input  logic [ID_W-1:0]    ptr_i,
    output logic [NUM_REQ-1:0] grant_o,
    output logic [ID_W-1:0]    idx_o
);

    logic [NUM_REQ-1:0] rot, rot_oh;

    // Rotate so ptr sits at bit 0, take the lowest set bit, rotate back.
    always_comb begin
        rot = '0;
        for (int k = 0; k < NUM_REQ; k++)
            rot[k] = req_i[(k + int'(ptr_i)) % NUM_REQ];
        rot_oh = rot & (-rot);
        grant_o = '0;
        for (int k = 0; k < NUM_REQ; k++)
            grant_o[(k + int'(ptr_i)) % NUM_REQ] = rot_oh[k];
        idx_o = ID_W'(onehot_to_bin(16'(grant_o)));
    end

endmodule

// File: rtl/serdes_tx_scheduler.sv
// serdes_tx_scheduler: shares one toggle-handshake serializer lane between NUM_REQ
// requesters, framing each burst as a header word followed by payload words.
module serdes_tx_scheduler
    import serdes_pkg::*;
#(
    parameter int NUM_REQ    = 4,
    parameter int DATA_WIDTH = 8,
    parameter int ID_W       = clog2(NUM_REQ),
    parameter logic [DATA_WIDTH-ID_W-1:0] HDR_MARK = (DATA_WIDTH-ID_W)'(HDR_MARK_DEF),
    parameter int MAX_BURST  = 16
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [NUM_REQ-1:0]            req_valid,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
    input  logic [NUM_REQ-1:0]            req_last,
    output logic [NUM_REQ-1:0]            req_ack,
    output logic [NUM_REQ-1:0]            grant,
    output logic                          ser_write,
    output logic [DATA_WIDTH-1:0]         ser_data,
    input  logic                          ser_busy,
    output logic                          frame_active
);

    state_t                  state_q;
    logic [NUM_REQ-1:0]      grant_q, ack_q, arb_grant;
    logic [ID_W-1:0]         gidx_q, rr_ptr_q, arb_idx;
    logic [7:0]              burst_q;
    logic                    guard_q, write_q, fa_q;
    logic [DATA_WIDTH-1:0]   data_q, pay_word;
    logic                    issue_ok, pay_go, pay_end;

    rr_arbiter #(.NUM_REQ(NUM_REQ), .ID_W(ID_W)) u_arb (
        .req_i   (req_valid),
        .ptr_i   (rr_ptr_q),
        .grant_o (arb_grant),
        .idx_o   (arb_idx)
    );

    // guard_q masks the cycle before the serializer reflects a toggle on busy.
    assign issue_ok = !ser_busy && !guard_q;
    assign pay_word = req_data[gidx_q*DATA_WIDTH +: DATA_WIDTH];
    assign pay_go   = issue_ok && req_valid[gidx_q];
    assign pay_end  = req_last[gidx_q] || (burst_q + 8'd1 == 8'(MAX_BURST));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            grant_q  <= '0;
            ack_q    <= '0;
            gidx_q   <= '0;
            rr_ptr_q <= '0;
            burst_q  <= '0;
            guard_q  <= 1'b0;
            write_q  <= 1'b0;
            fa_q     <= 1'b0;
            data_q   <= '0;
        end else begin
            ack_q   <= '0;
            guard_q <= 1'b0;
            case (state_q)
                IDLE: if (|req_valid) begin
                    grant_q <= arb_grant;
                    gidx_q  <= arb_idx;
                    state_q <= HDR;
                end
                HDR: if (issue_ok) begin
                    data_q  <= {HDR_MARK, gidx_q};
                    write_q <= ~write_q;
                    guard_q <= 1'b1;
                    fa_q    <= 1'b1;
                    state_q <= PAY;
                end
                PAY: if (pay_go) begin
                    data_q  <= pay_word;
                    write_q <= ~write_q;
                    guard_q <= 1'b1;
                    ack_q   <= grant_q;
                    burst_q <= burst_q + 8'd1;
                    state_q <= pay_end ? DRAIN : PAY;
                end
                DRAIN: if (issue_ok) begin
                    grant_q  <= '0;
                    fa_q     <= 1'b0;
                    rr_ptr_q <= gidx_q + ID_W'(1);
                    burst_q  <= '0;
                    state_q  <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign req_ack      = ack_q;
    assign grant        = grant_q;
    assign ser_write    = write_q;
    assign ser_data     = data_q;
    assign frame_active = fa_q;

endmodule

// File: tb/tb_serdes_tx_scheduler.sv
// tb_serdes_tx_scheduler: directed bench with a serializer/source model and a
// per-cycle checker comparing every issued word against an expected word stream.
module tb_serdes_tx_scheduler;

    localparam int N  = 4;
    localparam int DW = 8;
    localparam int MB = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic [N-1:0]    req_valid = '0, req_last = '0, req_ack, grant;
    logic [N*DW-1:0] req_data = '0;
    logic            ser_write, frame_active;
    logic            ser_busy = 1'b0;
    logic [DW-1:0]   ser_data;

    serdes_tx_scheduler #(
        .NUM_REQ(N), .DATA_WIDTH(DW), .ID_W(2), .HDR_MARK(6'b101101), .MAX_BURST(MB)
    ) dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_data(req_data),
        .req_last(req_last), .req_ack(req_ack), .grant(grant), .ser_write(ser_write),
        .ser_data(ser_data), .ser_busy(ser_busy), .frame_active(frame_active)
    );

    int tests = 0, fails = 0;
    logic [8:0]    src_q [N][$];
    logic [DW-1:0] exp_q [$];
    logic [N-1:0]  en = '1;
    int busy_len = 4, busy_cnt = 0, since = 100, tg_cnt = 0, tg0 = 0, t = 0;
    int acks_seen [N];
    logic prev_w = 1'b0, prev_fa = 1'b0, tg;
    logic [DW-1:0] prev_d = '0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        tests++;
        if (act !== req) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, req, $time);
        end
    endtask

    // Serializer model, source model and the per-cycle checker, all on negedge.
    always @(negedge clk) begin
        if (rst) begin
            prev_w = 1'b0; prev_d = '0; prev_fa = 1'b0;
            busy_cnt = 0; ser_busy = 1'b0; since = 100;
        end else begin
            tg = (ser_write !== prev_w);
            since++;
            if (tg) begin
                tg_cnt++;
                chk("busy_at_issue", 32'(ser_busy), 0);
                chk("guard_spacing", 32'(since >= 2), 1);
                chk("exp_pending", 32'(exp_q.size() != 0), 1);
                if (exp_q.size() != 0) chk("ser_data", 32'(ser_data), 32'(exp_q.pop_front()));
                chk("fa_on_toggle", 32'(frame_active), 1);
                if (!prev_fa) chk("hdr_no_ack", 32'(req_ack), 0);
                else begin
                    chk("ack_eq_grant", 32'(req_ack), 32'(grant));
                    chk("ack_onehot", 32'($onehot(req_ack)), 1);
                end
                since = 0;
            end else begin
                chk("data_stable", 32'(ser_data), 32'(prev_d));
                chk("no_ack_idle", 32'(req_ack), 0);
            end
            chk("grant_onehot0", 32'($onehot0(grant)), 1);
            if (prev_fa && !frame_active) chk("fa_fall_busy", 32'(ser_busy), 0);
            if (tg) busy_cnt = busy_len;
            else if (busy_cnt > 0) busy_cnt--;
            ser_busy = (busy_cnt > 0);
            for (int i = 0; i < N; i++)
                if (req_ack[i]) begin
                    acks_seen[i]++;
                    if (src_q[i].size() != 0) void'(src_q[i].pop_front());
                end
            prev_w = ser_write; prev_d = ser_data; prev_fa = frame_active;
        end
        for (int i = 0; i < N; i++) begin
            req_valid[i] = en[i] && (src_q[i].size() != 0);
            {req_last[i], req_data[i*DW +: DW]} = (src_q[i].size() != 0) ? src_q[i][0] : 9'h0;
        end
    end

    task automatic clear_model();
        for (int i = 0; i < N; i++) begin
            src_q[i].delete();
            acks_seen[i] = 0;
        end
        exp_q.delete();
        en = '1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        clear_model();
        repeat (2) @(negedge clk);
        #1 rst = 1'b0;
    endtask

    task automatic wait_done(input string name);
        int n;
        n = 0;
        while ((exp_q.size() != 0 || frame_active || grant != '0) && n < 2000) begin
            @(negedge clk); #1;
            n++;
        end
        chk({name, "_done"}, 32'(n < 2000), 1);
    endtask

    task automatic push(input int r, input logic [7:0] d, input logic last);
        src_q[r].push_back({last, d});
    endtask

    initial begin
        // Reset state
        do_reset();
        chk("rst_grant", 32'(grant), 0);
        chk("rst_ack", 32'(req_ack), 0);
        chk("rst_write", 32'(ser_write), 0);
        chk("rst_data", 32'(ser_data), 0);
        chk("rst_fa", 32'(frame_active), 0);

        // Single packet from requester 1
        tg0 = tg_cnt;
        exp_q = '{8'hB5, 8'hA1, 8'hA2, 8'hA3};
        push(1, 8'hA1, 0); push(1, 8'hA2, 0); push(1, 8'hA3, 1);
        t = 0;
        while ((exp_q.size() != 0 || frame_active || grant != '0 || t < 3) && t < 2000) begin
            @(negedge clk); #1;
            if (frame_active) chk("t1_grant", 32'(grant), 32'h2);
            t++;
        end
        chk("t1_done", 32'(t < 2000), 1);
        chk("t1_toggles", 32'(tg_cnt - tg0), 4);
        chk("t1_acks", 32'(acks_seen[1]), 3);

        // Round robin with every requester holding 1-word packets
        do_reset();
        tg0 = tg_cnt;
        exp_q = '{8'hB4, 8'hC0, 8'hB5, 8'hC1, 8'hB6, 8'hC2, 8'hB7, 8'hC3, 8'hB4, 8'hC4};
        push(0, 8'hC0, 1); push(0, 8'hC4, 1);
        push(1, 8'hC1, 1); push(2, 8'hC2, 1); push(3, 8'hC3, 1);
        @(negedge clk); #1;
        wait_done("t2");
        chk("t2_toggles", 32'(tg_cnt - tg0), 10);
        chk("t2_acks0", 32'(acks_seen[0]), 2);
        chk("t2_acks3", 32'(acks_seen[3]), 1);

        // Burst cap: 6-word packet truncated at 4, requester 0 served in between
        do_reset();
        tg0 = tg_cnt;
        exp_q = '{8'hB6, 8'hD0, 8'hD1, 8'hD2, 8'hD3, 8'hB4, 8'hE0, 8'hB6, 8'hD4, 8'hD5};
        for (int k = 0; k < 6; k++) push(2, 8'hD0 + 8'(k), k == 5);
        t = 0;
        while (grant != 4'b0100 && t < 100) begin @(negedge clk); #1; t++; end
        chk("t3_grant2", 32'(grant), 32'h4);
        push(0, 8'hE0, 1);
        wait_done("t3");
        chk("t3_toggles", 32'(tg_cnt - tg0), 10);
        chk("t3_acks2", 32'(acks_seen[2]), 6);

        // Long serializer busy
        do_reset();
        busy_len = 10;
        tg0 = tg_cnt;
        exp_q = '{8'hB4, 8'hF0, 8'hF1};
        push(0, 8'hF0, 0); push(0, 8'hF1, 1);
        @(negedge clk); #1;
        wait_done("t4");
        chk("t4_toggles", 32'(tg_cnt - tg0), 3);
        busy_len = 4;

        // Stall: requester 3 drops valid for 5 cycles mid-packet
        do_reset();
        exp_q = '{8'hB7, 8'h31, 8'h32, 8'h33, 8'h34};
        push(3, 8'h31, 0); push(3, 8'h32, 0); push(3, 8'h33, 0); push(3, 8'h34, 1);
        t = 0;
        while (acks_seen[3] < 2 && t < 200) begin @(negedge clk); #1; t++; end
        chk("t5_two_acks", 32'(acks_seen[3]), 2);
        en[3] = 1'b0;
        tg0 = tg_cnt;
        repeat (5) begin
            @(negedge clk); #1;
            chk("t5_gap_grant", 32'(grant), 32'h8);
            chk("t5_gap_ack", 32'(req_ack), 0);
        end
        chk("t5_gap_toggles", 32'(tg_cnt - tg0), 0);
        en[3] = 1'b1;
        wait_done("t5");
        chk("t5_acks", 32'(acks_seen[3]), 4);

        // Reset mid-frame, then arbitration restarts from requester 0
        do_reset();
        exp_q = '{8'hB6, 8'h60};
        push(2, 8'h60, 1);
        @(negedge clk); #1;
        wait_done("t6a");
        exp_q = '{8'hB5, 8'h71, 8'h72, 8'h73};
        push(1, 8'h71, 0); push(1, 8'h72, 0); push(1, 8'h73, 1);
        t = 0;
        while (acks_seen[1] < 2 && t < 200) begin @(negedge clk); #1; t++; end
        chk("t6_two_acks", 32'(acks_seen[1]), 2);
        rst = 1'b1;
        #1;
        chk("t6_rst_grant", 32'(grant), 0);
        chk("t6_rst_ack", 32'(req_ack), 0);
        chk("t6_rst_write", 32'(ser_write), 0);
        chk("t6_rst_data", 32'(ser_data), 0);
        chk("t6_rst_fa", 32'(frame_active), 0);
        clear_model();
        exp_q = '{8'hB4, 8'h80, 8'hB7, 8'h83};
        push(0, 8'h80, 1); push(3, 8'h83, 1);
        repeat (2) @(negedge clk);
        #1 rst = 1'b0;
        @(negedge clk); #1;
        wait_done("t6b");

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/serdes_tx_scheduler.md
Name: serdes_tx_scheduler

Overview:
- Round-robin transmit scheduler that shares one ddr_oserdes lane between NUM_REQ requesters.
- Grants the lane to one requester at a time and frames each burst as one header word followed by payload words.
- Drives the serializer's toggle-style write handshake and paces words against its busy signal.
- Sits between the per-channel packet sources and the single ddr_oserdes instance.

Parameters:
- NUM_REQ, 4, number of requesters; power of two, 2..16.
- DATA_WIDTH, 8, serializer word width; must equal the ddr_oserdes DATA_WIDTH.
- ID_W, 2, header channel-id width; ID_W = clog2(NUM_REQ).
- HDR_MARK, 6'b101101, constant placed in header bits [DATA_WIDTH-1:ID_W]; width is DATA_WIDTH-ID_W.
- MAX_BURST, 16, maximum payload words per frame (fairness cap), 1..255.

Ports:
- clk  in  1  clock; same clock as the serializer.
- rst  in  1  reset; asynchronous, active-high.
- req_valid  in  NUM_REQ  requester i has a payload word available.
- req_data  in  NUM_REQ*DATA_WIDTH  flattened payload words; slice i = [i*DATA_WIDTH +: DATA_WIDTH].
- req_last  in  NUM_REQ  word on slice i is the last word of its packet.
- req_ack  out  NUM_REQ  one-cycle pulse: word i was consumed this cycle.
- grant  out  NUM_REQ  one-hot owner of the lane; all zeros when idle.
- ser_write  out  1  toggle line to the serializer; each change issues one word.
- ser_data  out  DATA_WIDTH  word presented to the serializer; held stable between toggles.
- ser_busy  in  1  serializer busy_sig.
- frame_active  out  1  high from header issue until the end of the frame's final serializer busy.

Behaviour:
- Reset values: req_ack=0, grant=0, ser_write=0, ser_data=0, frame_active=0, rr_ptr=0, burst_cnt=0, state=IDLE.
- Async reset mid-frame: the frame is abandoned. No ack is issued for the word in flight, and that word is not replayed.
- Issue rule: ser_write toggles only in ISSUE states, and only when ser_busy=0 and guard=0.
  - guard is set in the cycle a toggle occurs and cleared on the next cycle.
  - guard covers the one-cycle delay before the serializer raises busy.
  - Consequence: words are never closer than 2 cycles apart.
- IDLE:
  - If req_valid is nonzero, select the first requester at or after rr_ptr, wrapping around.
  - Set grant, then go to HDR. grant becomes visible the cycle after selection.
- HDR (issue state):
  - On issue, ser_data = {HDR_MARK, id}, toggle ser_write, set frame_active=1, then go to PAY.
- PAY (issue state):
  - Wait for req_valid[g]=1 and the issue rule.
  - On issue, ser_data = slice g, toggle ser_write, pulse req_ack[g] the same cycle, and increment burst_cnt.
  - If req_last[g]=1 or burst_cnt reaches MAX_BURST, go to DRAIN; otherwise stay in PAY.
  - If req_valid[g]=0, the lane stalls with grant held. There is no timeout.
- DRAIN:
  - Wait for guard=0 and ser_busy=0.
  - Then clear grant and frame_active, set rr_ptr = g+1 mod NUM_REQ, clear burst_cnt, and go to IDLE.
- Truncated packet (cap hit without last): the requester's remaining words start a new frame with a new header when it next wins arbitration.
- Simultaneous requests: the winner is the lowest index at or after rr_ptr. A requester asserting valid while another frame is in DRAIN waits for IDLE.
- req_ack is never asserted for a non-granted requester. At most one req_ack bit is high per cycle.
- Width rules:
  - burst_cnt is 8 bits.
  - id is the binary index of g, zero-extended to ID_W.
  - rr_ptr wraps from NUM_REQ-1 to 0.

Decomposition:
- Package serdes_pkg holds:
  - state enum {IDLE, HDR, PAY, DRAIN}
  - HDR_MARK default
  - function clog2
  - function onehot_to_bin
- One natural sub-module: rr_arbiter (NUM_REQ). Inputs req and ptr; outputs one-hot grant and binary index. Purely combinational priority rotate.
- The scheduler FSM, guard and counters live in serdes_tx_scheduler.

Test Plan:
- Single packet: reset, then req_valid=4'b0010 with 3 words 8'hA1, 8'hA2, 8'hA3 (last on 8'hA3), serializer model 4-cycle busy.
  -> ser_data sequence 8'hB5, 8'hA1, 8'hA2, 8'hA3 with exactly 4 ser_write toggles.
  -> req_ack[1] pulses 3 times; grant=4'b0010 throughout; frame_active falls after the final busy clears.
- Round robin: all four requesters request 1-word packets continuously.
  -> Header ids follow 0, 1, 2, 3, 0. No requester is granted twice before the others.
- Burst cap: MAX_BURST=4, requester 2 sends a 6-word packet.
  -> Frame 1 carries header id 2 plus 4 words.
  -> Requester 0 (if requesting) is served next.
  -> Frame 2 carries header id 2 plus the 2 remaining words.
- Guard/busy pacing: ser_busy held high for 10 cycles after each toggle.
  -> No toggle while busy or within 1 cycle of the previous toggle.
  -> ser_data is stable between toggles.
- Stall: requester 3 drops req_valid for 5 cycles mid-packet.
  -> No toggle and no ack during the gap; grant stays 4'b1000.
  -> Transmission resumes with the next word.
- Reset mid-frame: assert rst after the 2nd payload toggle.
  -> All outputs are 0 immediately and state=IDLE.
  -> After release, a new request starts with a header and rr_ptr=0.
